// File: rtl/time_set_pkg.sv
// Shared constants for the serial time-setting receiver: ASCII codes of the
// "MM:SS" frame, receiver and parser state encodings, and a range helper.
// Optional feature macro: TIMESET_PARITY_EN (8E1 framing with even parity).
package time_set_pkg;

    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_5     = 8'h35;
    localparam logic [7:0] CH_9     = 8'h39;
    localparam logic [7:0] CH_COLON = 8'h3A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;

    typedef logic [2:0] rx_state_t;
    localparam rx_state_t RX_IDLE   = 3'd0;
    localparam rx_state_t RX_START  = 3'd1;
    localparam rx_state_t RX_DATA   = 3'd2;
    localparam rx_state_t RX_PARITY = 3'd3;
    localparam rx_state_t RX_STOP   = 3'd4;

    typedef logic [2:0] parse_state_t;
    localparam parse_state_t P_M10 = 3'd0;
    localparam parse_state_t P_M1  = 3'd1;
    localparam parse_state_t P_COL = 3'd2;
    localparam parse_state_t P_S10 = 3'd3;
    localparam parse_state_t P_S1  = 3'd4;
    localparam parse_state_t P_END = 3'd5;

    function automatic logic in_range(input logic [7:0] b,
                                      input logic [7:0] lo,
                                      input logic [7:0] hi);
        return (b >= lo) && (b <= hi);
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// Byte receiver: two-flop synchronizer plus previous-sample register, bit
// timer and receive FSM. Emits a one-cycle valid with the byte, or a
// one-cycle err when the stop bit (or, with TIMESET_PARITY_EN, the even
// parity bit) is wrong; a failed byte is never presented as valid.
module uart_rx_byte
    import time_set_pkg::*;
#(
    parameter int DIV = 434
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic       valid,
    output logic [7:0] data,
    output logic       err
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] FULL    = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF    = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic            sync1;
    logic            sync2;
    logic            prev;
    rx_state_t       state;
    logic [CW-1:0]   cnt;
    logic [2:0]      bitcnt;
    logic [7:0]      shift;
`ifdef TIMESET_PARITY_EN
    logic            perr;
`endif

    // Bring the asynchronous line into the clock domain and keep one older sample for edge detection
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= rxd;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // Receive FSM: find the start edge, verify it mid-bit, then sample each bit once per bit period
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= RX_IDLE;
            cnt    <= '0;
            bitcnt <= 3'd0;
            shift  <= 8'h00;
            data   <= 8'h00;
            valid  <= 1'b0;
            err    <= 1'b0;
`ifdef TIMESET_PARITY_EN
            perr   <= 1'b0;
`endif
        end else begin
            valid <= 1'b0;
            err   <= 1'b0;
            case (state)
                RX_IDLE: begin
                    cnt <= '0;
                    if (!sync2 && prev) begin
                        state <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt == HALF) begin
                        cnt <= '0;
                        if (sync2) begin
                            state <= RX_IDLE;
                        end else begin
                            state  <= RX_DATA;
                            bitcnt <= 3'd0;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                RX_DATA: begin
                    if (cnt == FULL) begin
                        cnt    <= '0;
                        shift  <= {sync2, shift[7:1]};
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) begin
`ifdef TIMESET_PARITY_EN
                            state <= RX_PARITY;
`else
                            state <= RX_STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
`ifdef TIMESET_PARITY_EN
                RX_PARITY: begin
                    if (cnt == FULL) begin
                        cnt   <= '0;
                        perr  <= (^shift) ^ sync2;
                        state <= RX_STOP;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
`endif
                RX_STOP: begin
                    if (cnt == FULL) begin
                        cnt   <= '0;
                        state <= RX_IDLE;
`ifdef TIMESET_PARITY_EN
                        if (!sync2 || perr) begin
`else
                        if (!sync2) begin
`endif
                            err <= 1'b1;
                        end else begin
                            valid <= 1'b1;
                            data  <= shift;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= RX_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/time_set_rx.sv
// Serial time-setting input for the MM:SS clock. Parses "MM:SS" followed by
// CR or LF from the UART byte stream and presents BCD digits with a
// one-cycle load strobe; any bad byte produces a one-cycle err strobe and
// restarts the frame. Optional macro: TIMESET_PARITY_EN (8E1 framing).
module time_set_rx
    import time_set_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic       load,
    output logic [2:0] minh,
    output logic [3:0] minl,
    output logic [2:0] sech,
    output logic [3:0] secl,
    output logic       err
);

    localparam int DIV = CLK_HZ / BAUD;

    logic         rx_valid;
    logic [7:0]   rx_data;
    logic         rx_err;
    parse_state_t pstate;
    logic         accept;
    logic [2:0]   m10;
    logic [3:0]   m1;
    logic [2:0]   s10;
    logic [3:0]   s1;

    uart_rx_byte #(
        .DIV (DIV)
    ) u_rx (
        .clk   (clk),
        .rst   (rst),
        .rxd   (rxd),
        .valid (rx_valid),
        .data  (rx_data),
        .err   (rx_err)
    );

    // Decide whether the received byte is legal for the current frame position
    always_comb begin
        accept = 1'b0;
        case (pstate)
            P_M10, P_S10: accept = in_range(rx_data, CH_0, CH_5);
            P_M1,  P_S1:  accept = in_range(rx_data, CH_0, CH_9);
            P_COL:        accept = (rx_data == CH_COLON);
            P_END:        accept = (rx_data == CH_CR) || (rx_data == CH_LF);
            default:      accept = 1'b0;
        endcase
    end

    // Frame parser: collect digits into shadow registers and publish them all at once on the terminator
    always_ff @(posedge clk) begin
        if (!rst) begin
            pstate <= P_M10;
            load   <= 1'b0;
            err    <= 1'b0;
            m10    <= 3'd0;
            m1     <= 4'd0;
            s10    <= 3'd0;
            s1     <= 4'd0;
            minh   <= 3'd0;
            minl   <= 4'd0;
            sech   <= 3'd0;
            secl   <= 4'd0;
        end else begin
            load <= 1'b0;
            err  <= 1'b0;
            if (rx_err) begin
                err    <= 1'b1;
                pstate <= P_M10;
            end else if (rx_valid) begin
                if (!accept) begin
                    err    <= 1'b1;
                    pstate <= P_M10;
                end else begin
                    case (pstate)
                        P_M10: begin
                            m10    <= rx_data[2:0];
                            pstate <= P_M1;
                        end
                        P_M1: begin
                            m1     <= rx_data[3:0];
                            pstate <= P_COL;
                        end
                        P_COL: begin
                            pstate <= P_S10;
                        end
                        P_S10: begin
                            s10    <= rx_data[2:0];
                            pstate <= P_S1;
                        end
                        P_S1: begin
                            s1     <= rx_data[3:0];
                            pstate <= P_END;
                        end
                        P_END: begin
                            load   <= 1'b1;
                            minh   <= m10;
                            minl   <= m1;
                            sech   <= s10;
                            secl   <= s1;
                            pstate <= P_M10;
                        end
                        default: begin
                            pstate <= P_M10;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_time_set_rx.sv
// Self-checking bench for time_set_rx. Runs at a reduced clock so one bit
// is 16 clocks, keeping the run short. Expected results come from a
// frame-level model that checks each received byte against the "MM:SS"
// template and counts the load/err strobes it should cause.
module tb_time_set_rx;

    localparam int CLK_HZ = 1_843_200;
    localparam int BAUD   = 115_200;
    localparam int DIV    = CLK_HZ / BAUD;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rxd = 1'b1;
    logic       load;
    logic [2:0] minh;
    logic [3:0] minl;
    logic [2:0] sech;
    logic [3:0] secl;
    logic       err;

    int checks = 0;
    int errors = 0;

    int loadSeen = 0;
    int errSeen  = 0;
    int bothSeen = 0;

    int          expLoads  = 0;
    int          expErrs   = 0;
    int          pos       = 0;
    logic [7:0]  pend [6];
    logic [13:0] expDigits = 14'd0;

    always #5 clk = ~clk;

    time_set_rx #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .rxd  (rxd),
        .load (load),
        .minh (minh),
        .minl (minl),
        .sech (sech),
        .secl (secl),
        .err  (err)
    );

    // Count strobes away from the active edge
    always @(negedge clk) begin
        if (rst) begin
            if (load) loadSeen++;
            if (err) errSeen++;
            if (load && err) bothSeen++;
        end
    end

    function automatic bit charOk(input int p, input logic [7:0] b);
        case (p)
            0, 3:    return (b >= 8'h30) && (b <= 8'h35);
            1, 4:    return (b >= 8'h30) && (b <= 8'h39);
            2:       return b == 8'h3A;
            5:       return (b == 8'h0D) || (b == 8'h0A);
            default: return 1'b0;
        endcase
    endfunction

    task automatic modelByte(input logic [7:0] b, input bit lineOk);
        if (!lineOk || !charOk(pos, b)) begin
            expErrs++;
            pos = 0;
        end else begin
            pend[pos] = b;
            pos++;
            if (pos == 6) begin
                expLoads++;
                expDigits = {3'(pend[0] - 8'h30), 4'(pend[1] - 8'h30),
                             3'(pend[3] - 8'h30), 4'(pend[4] - 8'h30)};
                pos = 0;
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic idle(input int bits);
        rxd = 1'b1;
        repeat (bits * DIV) @(negedge clk);
    endtask

    // Send one byte on the line and feed it to the model
    task automatic applyStimulus(input logic [7:0] b, input logic stopVal, input bit parFlip);
        rxd = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (DIV) @(negedge clk);
        end
`ifdef TIMESET_PARITY_EN
        rxd = (^b) ^ parFlip;
        repeat (DIV) @(negedge clk);
`endif
        rxd = stopVal;
        repeat (DIV) @(negedge clk);
        rxd = 1'b1;
        modelByte(b, stopVal && !parFlip);
    endtask

    task automatic sendFrame(input string s, input logic [7:0] term);
        for (int i = 0; i < s.len(); i++) begin
            applyStimulus(s[i], 1'b1, 1'b0);
        end
        if (term != 8'h00) applyStimulus(term, 1'b1, 1'b0);
    endtask

    task automatic checkFrame(input string tag);
        idle(2);
        checkOutput({tag, ".loads"}, loadSeen, expLoads);
        checkOutput({tag, ".errs"}, errSeen, expErrs);
        checkOutput({tag, ".digits"}, {18'd0, minh, minl, sech, secl}, {18'd0, expDigits});
    endtask

    initial begin
        logic [7:0] fr [6];
        int         mode;
        int         k;

        rst = 1'b0;
        rxd = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("reset.load", {31'd0, load}, 32'd0);
        checkOutput("reset.err", {31'd0, err}, 32'd0);
        checkOutput("reset.digits", {18'd0, minh, minl, sech, secl}, 32'd0);
        rst = 1'b1;
        idle(2);

        $display("[TB] basic frame");
        sendFrame("12:34", 8'h0D);
        checkFrame("t1");

        $display("[TB] back-to-back frames");
        sendFrame("59:59", 8'h0A);
        sendFrame("00:00", 8'h0D);
        checkFrame("t2");
        checkOutput("t2.twoLoads", loadSeen, 32'd3);

        $display("[TB] bad character recovery");
        sendFrame("12:34", 8'h0D);
        sendFrame("6", 8'h00);
        sendFrame("1:00", 8'h0D);
        checkFrame("t3a");
        sendFrame("01:00", 8'h0D);
        checkFrame("t3b");

        $display("[TB] framing error");
        applyStimulus(8'h31, 1'b0, 1'b0);
        idle(2);
        checkFrame("t4a");
        sendFrame("02:03", 8'h0D);
        checkFrame("t4b");

        $display("[TB] start glitch");
        rxd = 1'b0;
        repeat ((DIV * 4) / 10) @(negedge clk);
        rxd = 1'b1;
        checkFrame("t5glitch");

        $display("[TB] reset mid-frame");
        sendFrame("45:12", 8'h0D);
        checkFrame("t5pre");
        sendFrame("23", 8'h00);
        rxd = 1'b0;
        repeat (DIV) @(negedge clk);
        rxd = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        rxd = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        pos = 0;
        expDigits = 14'd0;
        checkOutput("t5rst.digits", {18'd0, minh, minl, sech, secl}, 32'd0);
        rst = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        rxd = 1'b1;
        checkFrame("t5lowHeld");
        sendFrame("33:44", 8'h0A);
        checkFrame("t5post");

`ifdef TIMESET_PARITY_EN
        $display("[TB] parity");
        sendFrame("12:34", 8'h0D);
        checkFrame("t6good");
        sendFrame("12:", 8'h00);
        applyStimulus(8'h33, 1'b1, 1'b1);
        sendFrame("4", 8'h0D);
        checkFrame("t6bad");
`endif

        $display("[TB] randomized frames");
        for (int n = 0; n < 12; n++) begin
            mode = int'($urandom_range(0, 3));
            fr[0] = 8'h30 + 8'($urandom_range(0, 5));
            fr[1] = 8'h30 + 8'($urandom_range(0, 9));
            fr[2] = 8'h3A;
            fr[3] = 8'h30 + 8'($urandom_range(0, 5));
            fr[4] = 8'h30 + 8'($urandom_range(0, 9));
            fr[5] = ($urandom_range(0, 1) == 0) ? 8'h0D : 8'h0A;
            if (mode == 2) begin
                k = int'($urandom_range(0, 5));
                fr[k] = 8'($urandom_range(0, 255));
            end
            if (mode == 3) begin
                applyStimulus(8'($urandom_range(0, 255)), 1'b0, 1'b0);
                idle(2);
            end
            for (int i = 0; i < 6; i++) begin
                applyStimulus(fr[i], 1'b1, 1'b0);
            end
            checkFrame("rand");
        end

        checkOutput("neverBoth", bothSeen, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
